// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
//   lsu_state_e   : FSM state encoding (SPLIT exists only with LSU_MISALIGN_SPLIT_EN)
//   F3_*          : RV32I load/store funct3 encodings
//   is_misaligned : alignment check for a request
//   extend        : sign/zero extension of a raw little-endian value by funct3
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
`ifdef LSU_MISALIGN_SPLIT_EN
    ,
    S_SPLIT
`endif
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Bytes are always aligned; funct3[1:0]=11 falls into the word rule.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic mis;
    case (funct3[1:0])
      F3_B[1:0]: mis = 1'b0;
      F3_H[1:0]: mis = addr_lo[0];
      default:   mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] funct3);
    logic [31:0] res;
    case (funct3)
      F3_B:    res = {{24{raw[7]}}, raw[7:0]};
      F3_BU:   res = {24'h0, raw[7:0]};
      F3_H:    res = {{16{raw[15]}}, raw[15:0]};
      F3_HU:   res = {16'h0, raw[15:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lsu_mem_if_if.sv
// Bus bundle between the core memory stage, the LSU and the data memory.
//   req_*     : request handshake from the core (valid/ready)
//   rsp_*     : one-cycle response pulse back to the core
//   mem_*     : data memory port (mem_rdata is combinational from the memory)
//   busy      : LSU is not idle
// Modports: slave = LSU view, master = core/memory environment view.
interface lsu_mem_if_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_misaligned;
  logic                  mem_wr_en;
  logic [2:0]            mem_funct3;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  busy;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_misaligned,
           mem_wr_en, mem_funct3, mem_addr, mem_wdata, busy
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_misaligned,
           mem_wr_en, mem_funct3, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/lsu_byte_assembler.sv
// Byte sequencer for split misaligned accesses (built only with LSU_MISALIGN_SPLIT_EN).
//   start   : misaligned request accepted; clears counter and assembly register
//   active  : FSM is in SPLIT
//   funct3  : captured request funct3 (selects 2 or 4 bytes and final extension)
//   byte_in : mem_rdata[7:0] of the current byte load
//   idx     : current byte index i
//   done    : all bytes issued (one idle slot before the response)
//   result  : assembled and extended load value
module lsu_byte_assembler
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        active,
  input  logic [2:0]  funct3,
  input  logic [7:0]  byte_in,
  output logic [1:0]  idx,
  output logic        done,
  output logic [31:0] result
);
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] asm_q, asm_d;
  logic [2:0]  n_bytes;

  always_comb begin
    n_bytes = (funct3[1:0] == F3_H[1:0]) ? 3'd2 : 3'd4;
    done    = (cnt_q == n_bytes);
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    if (start) begin
      cnt_d = '0;
      asm_d = '0;
    end else if (active && !done) begin
      cnt_d = cnt_q + 3'd1;
      asm_d[{cnt_q[1:0], 3'b000} +: 8] = byte_in;
    end
  end

  assign idx    = cnt_q[1:0];
  assign result = extend(asm_q, funct3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      asm_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      asm_q <= asm_d;
    end
  end
endmodule

// File: rtl/lsu_mem_if.sv
// Load/store unit in front of the data memory. One request at a time:
// IDLE -> ACCESS -> RESP for aligned accesses (response 2 cycles after accept).
// Misaligned accesses are reported (IDLE -> RESP, rsp_misaligned=1, no write)
// unless LSU_MISALIGN_SPLIT_EN is defined, in which case they are split into
// byte accesses in SPLIT and answered N+2 cycles after accept.
// Ports: clk, rst_n (async active-low), bus (lsu_mem_if_if.slave: request,
// response, memory port and busy).
module lsu_mem_if
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic          clk,
  input logic          rst_n,
  lsu_mem_if_if.slave  bus
);
  lsu_state_e            state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            f3_q, f3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_mis_q, rsp_mis_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  busy_q, busy_d;
  logic                  req_mis;

  assign req_mis = is_misaligned(bus.req_funct3, bus.req_addr[1:0]);

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [1:0]  asm_idx;
  logic        asm_done;
  logic [31:0] asm_result;

  lsu_byte_assembler u_asm (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  ((state_q == S_IDLE) && bus.req_valid && req_mis),
    .active (state_q == S_SPLIT),
    .funct3 (f3_q),
    .byte_in(bus.mem_rdata[7:0]),
    .idx    (asm_idx),
    .done   (asm_done),
    .result (asm_result)
  );
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no latch is inferred.
    state_d     = state_q;
    we_d        = we_q;
    f3_d        = f3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_mis_d   = rsp_mis_q;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          we_d        = bus.req_we;
          f3_d        = bus.req_funct3;
          addr_d      = bus.req_addr;
          wdata_d     = bus.req_wdata;
          rsp_rdata_d = '0;
          rsp_mis_d   = 1'b0;
          if (!req_mis) begin
            state_d = S_ACCESS;
          end else begin
`ifdef LSU_MISALIGN_SPLIT_EN
            state_d = S_SPLIT;
`else
            state_d   = S_RESP;
            rsp_mis_d = 1'b1;
`endif
          end
        end
      end
      S_ACCESS: begin
        if (!we_q) rsp_rdata_d = bus.mem_rdata;
        state_d = S_RESP;
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      S_SPLIT: begin
        if (asm_done) begin
          if (!we_q) rsp_rdata_d = asm_result;
          state_d = S_RESP;
        end
      end
`endif
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    rsp_valid_d = (state_d == S_RESP);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: captured request fields are reset too, so the memory port and
      // the response read all-zero straight out of reset.
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      f3_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_mis_q   <= 1'b0;
      rsp_rdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_mis_q   <= rsp_mis_d;
      rsp_rdata_q <= rsp_rdata_d;
      busy_q      <= busy_d;
    end
  end

  // Memory port decodes from state, so resetting state_q kills a pending
  // write immediately without waiting for a clock edge.
  logic                  mem_wr_en_c;
  logic [2:0]            mem_funct3_c;
  logic [ADDR_WIDTH-1:0] mem_addr_c;
  logic [DATA_WIDTH-1:0] mem_wdata_c;

  always_comb begin
    mem_wr_en_c  = 1'b0;
    mem_funct3_c = '0;
    mem_addr_c   = '0;
    mem_wdata_c  = '0;
    case (state_q)
      S_ACCESS: begin
        mem_wr_en_c  = we_q;
        mem_funct3_c = f3_q;
        mem_addr_c   = addr_q;
        mem_wdata_c  = wdata_q;
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      S_SPLIT: begin
        // The final slot (asm_done) only lets the assembler settle; no access.
        mem_wr_en_c  = we_q & ~asm_done;
        mem_funct3_c = we_q ? F3_B : F3_BU;
        mem_addr_c   = addr_q + ADDR_WIDTH'(asm_idx);
        mem_wdata_c  = wdata_q >> {asm_idx, 3'b000};
      end
`endif
      default: ;
    endcase
  end

  assign bus.mem_wr_en      = mem_wr_en_c;
  assign bus.mem_funct3     = mem_funct3_c;
  assign bus.mem_addr       = mem_addr_c;
  assign bus.mem_wdata      = mem_wdata_c;
  assign bus.req_ready      = ~busy_q;
  assign bus.busy           = busy_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_misaligned = rsp_mis_q;
  assign bus.rsp_rdata      = rsp_rdata_q;
endmodule

// File: tb/tb_lsu_mem_if.sv
// Self-checking bench for lsu_mem_if with a byte-addressed data memory model
// and a response scoreboard. Expectations follow LSU_MISALIGN_SPLIT_EN.
module tb_lsu_mem_if;
  import lsu_pkg::*;

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_if_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  lsu_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Data memory model: 256 bytes, address taken modulo 256, zero at start.
  logic [7:0]  mem [256] = '{default: 8'h00};
  logic [7:0]  rd_a;
  logic [31:0] rd_w;

  always_comb begin
    rd_a = bus.mem_addr[7:0];
    rd_w = {mem[rd_a + 8'd3], mem[rd_a + 8'd2], mem[rd_a + 8'd1], mem[rd_a]};
    case (bus.mem_funct3)
      3'b000:  bus.mem_rdata = {{24{rd_w[7]}}, rd_w[7:0]};
      3'b100:  bus.mem_rdata = {24'h0, rd_w[7:0]};
      3'b001:  bus.mem_rdata = {{16{rd_w[15]}}, rd_w[15:0]};
      3'b101:  bus.mem_rdata = {16'h0, rd_w[15:0]};
      default: bus.mem_rdata = rd_w;
    endcase
  end

  always @(posedge clk) begin
    if (bus.mem_wr_en) begin
      mem[bus.mem_addr[7:0]] <= bus.mem_wdata[7:0];
      if (bus.mem_funct3[1:0] != 2'b00) mem[bus.mem_addr[7:0] + 8'd1] <= bus.mem_wdata[15:8];
      if (bus.mem_funct3[1]) begin
        mem[bus.mem_addr[7:0] + 8'd2] <= bus.mem_wdata[23:16];
        mem[bus.mem_addr[7:0] + 8'd3] <= bus.mem_wdata[31:24];
      end
    end
  end

  // Checking
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Scoreboard entry: response data, misaligned flag, latency in cycles from
  // the accept edge, and number of cycles with mem_wr_en high.
  typedef struct packed {
    logic [31:0] rdata;
    logic        mis;
    logic [7:0]  lat;
    logic [7:0]  wr;
  } exp_t;

  function automatic exp_t mk(input logic [31:0] r, input logic m, input int l, input int w);
    exp_t e;
    e.rdata = r;
    e.mis   = m;
    e.lat   = 8'(l);
    e.wr    = 8'(w);
    return e;
  endfunction

  exp_t sb[$];
  int   accept_log[$];
  int   cyc = 0;
  int   accept_cyc = 0;
  int   wr_cnt = 0;
  int   rsp_n = 0;
  exp_t cur;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_wr_en) wr_cnt++;
      if (bus.rsp_valid) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
        end else begin
          cur = sb.pop_front();
          check($sformatf("rsp%0d_rdata", rsp_n), bus.rsp_rdata, cur.rdata);
          check($sformatf("rsp%0d_mis", rsp_n), 32'(bus.rsp_misaligned), 32'(cur.mis));
          check($sformatf("rsp%0d_lat", rsp_n), 32'(cyc - accept_cyc), 32'(cur.lat));
          check($sformatf("rsp%0d_wr", rsp_n), 32'(wr_cnt), 32'(cur.wr));
          rsp_n++;
        end
      end
      if (bus.req_valid && bus.req_ready) begin
        accept_cyc = cyc;
        wr_cnt     = 0;
        accept_log.push_back(cyc);
      end
    end
  end

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
  endtask

  task automatic wait_accept();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.req_ready && n < 20);
    if (!bus.req_ready) check("accept_timeout", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input exp_t e);
    @(posedge clk);
    #1;
    sb.push_back(e);
    drive(we, f3, addr, wdata);
    bus.req_valid = 1'b1;
    wait_accept();
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    drain();
  endtask

  logic [31:0] b2b_addr [3] = '{32'h10, 32'h10, 32'h11};
  logic [2:0]  b2b_f3   [3] = '{3'b010, 3'b000, 3'b100};
  exp_t        b2b_exp  [3];

  initial begin
    bus.req_valid = 1'b0;
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_mis", 32'(bus.rsp_misaligned), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_mem_wr_en", 32'(bus.mem_wr_en), 32'd0);
    check("rst_mem_funct3", 32'(bus.mem_funct3), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);

    // Aligned store, then loads of every width.
    send(1'b1, F3_W,  32'h10, 32'hDEADBEEF, mk(32'h0, 1'b0, 2, 1));
    send(1'b0, F3_W,  32'h10, 32'h0,        mk(32'hDEADBEEF, 1'b0, 2, 0));
    send(1'b0, F3_B,  32'h13, 32'h0,        mk(32'hFFFFFFDE, 1'b0, 2, 0));
    send(1'b0, F3_BU, 32'h13, 32'h0,        mk(32'h000000DE, 1'b0, 2, 0));
    send(1'b0, F3_H,  32'h10, 32'h0,        mk(32'hFFFFBEEF, 1'b0, 2, 0));
    send(1'b0, F3_HU, 32'h12, 32'h0,        mk(32'h0000DEAD, 1'b0, 2, 0));

    // Misaligned store: reported, or split into two byte stores.
    send(1'b1, F3_H, 32'h11, 32'h1234, mk(32'h0, !SPLIT, SPLIT ? 4 : 1, SPLIT ? 2 : 0));
    send(1'b0, F3_W, 32'h10, 32'h0,
         mk(SPLIT ? 32'hDE1234EF : 32'hDEADBEEF, 1'b0, 2, 0));
    send(1'b0, F3_W, 32'h11, 32'h0, mk(SPLIT ? 32'h00DE1234 : 32'h0, !SPLIT, SPLIT ? 6 : 1, 0));

    // Misaligned halfword loads with sign/zero extension.
    send(1'b1, F3_B,  32'h18, 32'h000000F0, mk(32'h0, 1'b0, 2, 1));
    send(1'b0, F3_H,  32'h17, 32'h0, mk(SPLIT ? 32'hFFFFF000 : 32'h0, !SPLIT, SPLIT ? 4 : 1, 0));
    send(1'b0, F3_HU, 32'h17, 32'h0, mk(SPLIT ? 32'h0000F000 : 32'h0, !SPLIT, SPLIT ? 4 : 1, 0));

    // Address wrap at the top of the address space.
    send(1'b1, F3_B, 32'h00000000, 32'h0000005A, mk(32'h0, 1'b0, 2, 1));
    send(1'b1, F3_B, 32'hFFFFFFFF, 32'h000000C3, mk(32'h0, 1'b0, 2, 1));
    send(1'b0, F3_W, 32'hFFFFFFFE, 32'h0, mk(SPLIT ? 32'h005AC300 : 32'h0, !SPLIT, SPLIT ? 6 : 1, 0));

    // Reset during the ACCESS cycle of a store.
    @(posedge clk);
    #1;
    drive(1'b1, F3_W, 32'h20, 32'h55);
    bus.req_valid = 1'b1;
    wait_accept();
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("rstmid_wr_before", 32'(bus.mem_wr_en), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rstmid_wr_async", 32'(bus.mem_wr_en), 32'd0);
    check("rstmid_busy", 32'(bus.busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstmid_ready", 32'(bus.req_ready), 32'd1);
    send(1'b0, F3_W, 32'h20, 32'h0, mk(32'h0, 1'b0, 2, 0));

    // Back-to-back loads with req_valid held high throughout.
    b2b_exp[0] = mk(SPLIT ? 32'hDE1234EF : 32'hDEADBEEF, 1'b0, 2, 0);
    b2b_exp[1] = mk(32'hFFFFFFEF, 1'b0, 2, 0);
    b2b_exp[2] = mk(SPLIT ? 32'h00000034 : 32'h000000BE, 1'b0, 2, 0);
    @(posedge clk);
    #1;
    accept_log.delete();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, b2b_f3[k], b2b_addr[k], 32'h0);
      bus.req_valid = 1'b1;
      sb.push_back(b2b_exp[k]);
      wait_accept();
      @(negedge clk);
      check($sformatf("b2b%0d_ready_access", k), 32'(bus.req_ready), 32'd0);
      @(negedge clk);
      check($sformatf("b2b%0d_ready_resp", k), 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid = 1'b0;
    drain();
    check("b2b_accepts", 32'(accept_log.size()), 32'd3);
    if (accept_log.size() == 3) begin
      check("b2b_gap01", 32'(accept_log[1] - accept_log[0]), 32'd3);
      check("b2b_gap12", 32'(accept_log[2] - accept_log[1]), 32'd3);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/lsu_mem_if.md
Name: lsu_mem_if

Overview:
Load/store unit directly upstream of the data memory. Accepts one load/store request at a time from the core's memory stage over a valid/ready handshake. Drives the data memory port (write enable, funct3, address, write data) and returns the load result. Detects misaligned accesses; with the optional macro defined, it splits them into byte accesses instead of reporting them.

Parameters:
ADDR_WIDTH, 32, request/memory address width
DATA_WIDTH, 32, data width (fixed at 32 for RV32I)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted this cycle when high together with req_valid
req_we  in  1  1=store, 0=load
req_funct3  in  3  RV32I load/store funct3
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  store data (low bytes used for SB/SH)
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_WIDTH  load result, extended; 0 for stores
rsp_misaligned  out  1  valid with rsp_valid; access was misaligned and not performed
mem_wr_en  out  1  to data memory write enable
mem_funct3  out  3  to data memory funct3
mem_addr  out  ADDR_WIDTH  to data memory address
mem_wdata  out  DATA_WIDTH  to data memory write data
mem_rdata  in  DATA_WIDTH  combinational read data from the data memory
busy  out  1  state != IDLE

Behaviour:
- Reset: the state goes to IDLE. rsp_valid, rsp_misaligned, rsp_rdata, mem_wr_en, mem_funct3, mem_addr and mem_wdata are all 0. busy is 0 and req_ready is 1.
- Memory outputs decode from the state and captured-request registers. Asserting rst_n low drops mem_wr_en asynchronously, and any in-flight store is discarded.
- FSM states: IDLE, ACCESS, SPLIT, RESP.
- req_ready is 1 only in IDLE.
- Accepting a request (req_valid & req_ready at the clock edge) captures we, funct3, addr and wdata.
  - Aligned access: go to ACCESS.
  - Misaligned access without the macro: go to RESP with rsp_misaligned=1.
- Alignment rules:
  - A byte access is always aligned.
  - A halfword access is misaligned when addr[0]=1.
  - A word access is misaligned when addr[1:0]!=0.
  - funct3[1:0]=11 is treated as a word access.
- ACCESS lasts one cycle.
  - mem_addr, mem_funct3 and mem_wdata carry the captured values.
  - For stores, mem_wr_en=1 for exactly this cycle.
  - For loads, mem_wr_en=0 and rsp_rdata <= mem_rdata at the end of the cycle. The memory already performs byte/half selection and extension.
  - Next state is RESP.
- RESP lasts one cycle with rsp_valid=1, then the FSM returns to IDLE. There is no response back-pressure; the consumer must take the pulse.
- Latency: accept at edge T, ACCESS in cycle T+1, rsp_valid in cycle T+2. Throughput is one request per 3 cycles.
- A misaligned response (macro off) has rsp_rdata=0 and no memory write ever occurs.
- A store response has rsp_rdata=0.
- req_valid held high while busy is ignored. The requester holds the request until req_ready.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.

Optional Feature:
Macro: LSU_MISALIGN_SPLIT_EN.
- Defined: a misaligned access goes to SPLIT instead of RESP.
  - SPLIT issues N byte accesses (N=2 for half, N=4 for word), one per cycle, with byte counter i=0..N-1.
  - Each access uses mem_addr=addr+i (wrapping) and mem_funct3=3'b100 for loads or 3'b000 for stores.
  - Stores write wdata byte i.
  - Loads place mem_rdata[7:0] into byte i of an assembly register. After the last byte, a halfword result is sign-extended if funct3[2]=0, otherwise zero-extended.
  - The FSM then goes to RESP with rsp_misaligned=0.
  - Latency is N+2 cycles from the accept edge.
- Undefined: the SPLIT state and byte counter are absent, and misaligned accesses are reported as described in Behaviour.

Decomposition:
- Package lsu_pkg:
  - State enumeration.
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - Misalignment check function.
  - Width-extension helper.
- One natural sub-module, lsu_byte_assembler: the byte counter, assembly register and final extension. It is instantiated only under LSU_MISALIGN_SPLIT_EN.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> mem_wr_en high for exactly one cycle; LW returns rsp_rdata=0xDEADBEEF with rsp_valid 2 cycles after the accept edge.
- After the previous step: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
- Macro off: SH 0x11 data 0x1234 -> rsp_misaligned=1 and mem_wr_en never high; a later LW 0x10 still returns 0xDEADBEEF.
- Macro on: SH 0x11 data 0x1234 -> two SB cycles and rsp_valid 4 cycles after accept; LW 0x10 then returns 0xDE1234EF; LW 0x11 returns 0xxxDE1234 from bytes 0x11..0x14.
- rst_n pulled low during ACCESS of SW 0x20 data 0x55 -> mem_wr_en falls immediately, no rsp_valid, req_ready=1 after release, and LW 0x20 does not return 0x55 (from a zero-initialised memory it returns 0).
- req_valid held high for 3 back-to-back loads -> accepts occur 3 cycles apart, req_ready=0 in ACCESS and RESP, and responses arrive in order.
